conv_window_gen: RTL and testbench
==================================

Name: conv_window_gen

Overview:
- Streaming sliding-window generator that feeds the convolution datapath.
- Accepts one pixel per cycle in raster order. Holds SIZE-1 previous image rows in internal line buffers.
- Emits each fully populated SIZE x SIZE neighbourhood as a matrix in the same layout the convolution unit consumes: element [0][0] is the top-left pixel.
- Valid-only windows: no padding. Supports output back-pressure and back-to-back frames.

Parameters:
- SIZE, 3, window edge length (rows = columns); must be >= 2.
- WIDTH_BIT, 8, bits per pixel.
- IMG_W, 8, image width in pixels; must be >= SIZE.
- IMG_H, 8, image height in pixels; must be >= SIZE.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- pixel_i  input  WIDTH_BIT  incoming pixel, raster order.
- pixel_valid_i  input  1  pixel_i is valid this cycle.
- pixel_ready_o  output  1  block can accept a pixel this cycle.
- window_o  output  WIDTH_BIT x [SIZE-1:0][SIZE-1:0] (unpacked)  current window; [r][c], r=0 is the oldest row, c=0 is the leftmost column.
- window_valid_o  output  1  window_o holds a new, unconsumed window.
- window_ready_i  input  1  downstream consumes the window this cycle.
- frame_last_o  output  1  qualifies window_valid_o: this is the final window of the frame.

Behaviour:
- Reset (async assert, clean release on the next edge):
  - Cleared: col counter, row counter, window_valid_o, frame_last_o, window_o (all elements 0).
  - Line-buffer RAM contents are not cleared.
- Ready and accept:
  - pixel_ready_o = !window_valid_o || window_ready_i (combinational).
  - Accept = pixel_valid_i && pixel_ready_o.
  - No state changes on cycles without an accept, except the output drop described below.
- Counters:
  - col runs 0..IMG_W-1; row runs 0..IMG_H-1; widths are $clog2 of the respective bound.
  - On accept: col increments. At col==IMG_W-1, col wraps to 0 and row increments.
  - At row==IMG_H-1 and col==IMG_W-1, both wrap to 0: a new frame starts with no idle cycle.
- Line buffers:
  - SIZE-1 buffers, each IMG_W deep, addressed by col.
  - On accept, the column at address col is read and then shifted: buffer k gets buffer k+1's old value; the last buffer gets pixel_i.
  - Read-before-write at the same address within a cycle.
- Window shift register:
  - On accept, every row shifts one column left (c gets c+1).
  - The new right column c=SIZE-1 is loaded with: rows 0..SIZE-2 from line buffers 0..SIZE-2 at address col (pre-update values); row SIZE-1 from pixel_i.
  - The shift register copies straight into window_o; there is no separate staging register.
- Output:
  - Window emit condition: the accepted pixel has row >= SIZE-1 and col >= SIZE-1. window_valid_o is set on the next edge; latency is 1 cycle from accept.
  - frame_last_o is set together with window_valid_o when the accepted pixel is (IMG_H-1, IMG_W-1); it is cleared with the next window_valid_o update.
  - Columns 0..SIZE-2 of each row contain stale data from the previous row. The emit condition masks them, and the window shift still occurs for those pixels.
  - While window_valid_o=1 and window_ready_i=0: pixel_ready_o=0, and window_o, window_valid_o and frame_last_o hold.
  - On a cycle with window_ready_i=1 and no emitting accept, window_valid_o and frame_last_o drop to 0 at the next edge.
  - Consume and emitting accept in the same cycle: window_valid_o stays 1 with the new window (full throughput).
- Window count per frame = (IMG_H-SIZE+1)*(IMG_W-SIZE+1).
- Reset mid-frame: the partial frame is discarded; the next accepted pixel is treated as (0,0).
- window_o is driven from registers only: no combinational path from pixel_i.

Test Plan (SIZE=3, IMG_W=5, IMG_H=4, pixel value = row*5+col, i.e. 0..19):
- Continuous stream, window_ready_i=1:
  - First window_valid_o comes the cycle after pixel 12: window_o = {{0,1,2},{5,6,7},{10,11,12}}.
  - Exactly 6 windows per frame; frame_last_o only on the last one, {{7,8,9},{12,13,14},{17,18,19}}.
- Row boundary: the window after pixel 17 is {{5,6,7},{10,11,12},{15,16,17}}. No window after pixels 15 or 16, and no window containing the 14->15 wrap.
- Back-pressure: hold window_ready_i=0 when the first window appears.
  - pixel_ready_o=0; window_o stays at the first window for 10 cycles.
  - Release: the next window {{1,2,3},{6,7,8},{11,12,13}} follows one cycle after pixel 13 is accepted; no pixel is lost.
- Gapped input: random pixel_valid_i at 50% duty → the same 6 windows in order, values identical to the continuous case.
- Back-to-back frames: two frames with no gap, the second using values +100 → the second frame's first window is {{100,101,102},{105,106,107},{110,111,112}}; frame_last_o fires twice in total.
- Async reset mid-frame:
  - Assert reset between pixels 8 and 9 → window_valid_o, frame_last_o and the counters go to 0 immediately.
  - A fresh frame afterwards yields the same 6 windows as the first scenario.

Source files
------------

// File: rtl/conv_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_gen
// Purpose  : Streaming SIZE x SIZE sliding-window generator for the
//            convolution datapath. Takes one raster-order pixel per cycle,
//            keeps SIZE-1 previous rows in line buffers and emits every fully
//            populated neighbourhood (no padding) with valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module conv_window_gen #(
    parameter int SIZE      = 3,
    parameter int WIDTH_BIT = 8,
    parameter int IMG_W     = 8,
    parameter int IMG_H     = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WIDTH_BIT-1:0] pixel_i,
    input  logic                 pixel_valid_i,
    output logic                 pixel_ready_o,
    output logic [WIDTH_BIT-1:0] window_o [SIZE-1:0][SIZE-1:0],
    output logic                 window_valid_o,
    input  logic                 window_ready_i,
    output logic                 frame_last_o
);

    localparam int c_COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int c_ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_H - 1);
    localparam logic [c_COL_W-1:0] c_COL_EMIT = c_COL_W'(SIZE - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_EMIT = c_ROW_W'(SIZE - 1);

    logic [c_COL_W-1:0]   r_col;
    logic [c_ROW_W-1:0]   r_row;
    logic                 r_valid;
    logic                 r_last;

    // Line buffers: index 0 holds the oldest row, SIZE-2 the row just above.
    logic [WIDTH_BIT-1:0] r_line [SIZE-1][IMG_W];

    // Window shift register, [row][column], row 0 oldest, column 0 leftmost.
    logic [WIDTH_BIT-1:0] r_win [SIZE-1:0][SIZE-1:0];

    logic                 w_accept;
    logic                 w_emit;
    logic                 w_frame_end;

    // Handshake and emit qualification for the pixel presented this cycle.
    always_comb begin
        pixel_ready_o = !r_valid || window_ready_i;
        w_accept      = pixel_valid_i && pixel_ready_o;
        w_emit        = w_accept && (r_row >= c_ROW_EMIT) && (r_col >= c_COL_EMIT);
        w_frame_end   = (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);
    end

    // Raster position counters; wrap straight into the next frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (r_col == c_COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Line-buffer column shift at address col; reads see pre-update contents.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            for (int k = 0; k < SIZE - 2; k++) begin
                r_line[k][r_col] <= r_line[k+1][r_col];
            end
            r_line[SIZE-2][r_col] <= pixel_i;
        end
    end

    // Window shifts left on every accept, including masked edge pixels.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < SIZE; r++) begin
                for (int c = 0; c < SIZE; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int r = 0; r < SIZE; r++) begin
                for (int c = 0; c < SIZE - 1; c++) begin
                    r_win[r][c] <= r_win[r][c+1];
                end
            end
            for (int r = 0; r < SIZE - 1; r++) begin
                r_win[r][SIZE-1] <= r_line[r][r_col];
            end
            r_win[SIZE-1][SIZE-1] <= pixel_i;
        end
    end

    // Output valid / frame-last: set on emit, dropped once consumed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_emit) begin
            r_valid <= 1'b1;
            r_last  <= w_frame_end;
        end else if (window_ready_i) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign window_o       = r_win;
    assign window_valid_o = r_valid;
    assign frame_last_o   = r_last;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_window_gen
// Purpose  : Self-checking bench for conv_window_gen (SIZE=3, 5x4 image).
//            A frame-array model derives every expected window directly from
//            the accepted pixel positions; hand-written windows pin it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_window_gen;

    localparam int SIZE      = 3;
    localparam int WIDTH_BIT = 8;
    localparam int IMG_W     = 5;
    localparam int IMG_H     = 4;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [WIDTH_BIT-1:0] pixel_i;
    logic                 pixel_valid_i;
    logic                 pixel_ready_o;
    logic [WIDTH_BIT-1:0] window_o [SIZE-1:0][SIZE-1:0];
    logic                 window_valid_o;
    logic                 window_ready_i;
    logic                 frame_last_o;

    conv_window_gen #(
        .SIZE      (SIZE),
        .WIDTH_BIT (WIDTH_BIT),
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H)
    ) u_dut (
        .clock          (clock),
        .reset          (reset),
        .pixel_i        (pixel_i),
        .pixel_valid_i  (pixel_valid_i),
        .pixel_ready_o  (pixel_ready_o),
        .window_o       (window_o),
        .window_valid_o (window_valid_o),
        .window_ready_i (window_ready_i),
        .frame_last_o   (frame_last_o)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        last;
        logic [71:0] px;
    } exp_t;

    int   n_checks = 0;
    int   n_err    = 0;
    exp_t expq[$];
    exp_t mlog[$];
    int   img [IMG_H][IMG_W];
    int   m_row = 0;
    int   m_col = 0;
    bit   exp_valid = 1'b0;
    int   got_win  = 0;
    int   got_last = 0;
    int   tl6 [6] = '{0, 1, 2, 5, 6, 7};

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [71:0] dut_win();
        logic [71:0] v;
        v = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                v[(i*3+j)*8 +: 8] = window_o[i][j];
        return v;
    endfunction

    // Window whose top-left pixel has value t in a row*5+col numbered image.
    function automatic logic [71:0] exp_at(input int t);
        logic [71:0] v;
        v = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                v[(i*3+j)*8 +: 8] = 8'(t + i*5 + j);
        return v;
    endfunction

    function automatic int pix_val(input int p);
        return (p / 20) * 100 + (p % 20);
    endfunction

    // Reference model and compare, sampled mid-cycle.
    always @(negedge clock) begin
        bit   consume;
        bit   acc;
        exp_t e;
        if (reset) begin
            m_row = 0;
            m_col = 0;
            exp_valid = 1'b0;
            expq.delete();
        end else begin
            chk("valid", {71'b0, window_valid_o}, {71'b0, exp_valid});
            chk("pixel_ready", {71'b0, pixel_ready_o}, {71'b0, (!exp_valid || window_ready_i)});
            if (exp_valid) begin
                if (expq.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL model_queue: got=empty expected=entry at %0t", $time);
                end else begin
                    chk("window", dut_win(), expq[0].px);
                    chk("frame_last", {71'b0, frame_last_o}, {71'b0, expq[0].last});
                end
            end else begin
                chk("frame_last_idle", {71'b0, frame_last_o}, 72'd0);
            end
            consume = exp_valid && window_ready_i;
            if (consume) begin
                got_win++;
                if (frame_last_o) got_last++;
                if (expq.size() > 0) void'(expq.pop_front());
            end
            acc = pixel_valid_i && (!exp_valid || window_ready_i);
            if (acc) begin
                img[m_row][m_col] = int'(pixel_i);
                if (m_row >= SIZE - 1 && m_col >= SIZE - 1) begin
                    e.px = '0;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            e.px[(i*3+j)*8 +: 8] = 8'(img[m_row-2+i][m_col-2+j]);
                    e.last = (m_row == IMG_H - 1) && (m_col == IMG_W - 1);
                    expq.push_back(e);
                    mlog.push_back(e);
                    exp_valid = 1'b1;
                end else if (window_ready_i) begin
                    exp_valid = 1'b0;
                end
                m_col++;
                if (m_col == IMG_W) begin
                    m_col = 0;
                    m_row = (m_row == IMG_H - 1) ? 0 : m_row + 1;
                end
            end else if (window_ready_i) begin
                exp_valid = 1'b0;
            end
        end
    end

    task automatic send(input int first, input int count, input int vpct, input int rpct);
        int  idx;
        int  guard;
        bit  acc;
        idx   = first;
        guard = 0;
        while (idx < first + count) begin
            pixel_valid_i  = ($urandom_range(99) < vpct);
            pixel_i        = 8'(pix_val(idx));
            window_ready_i = ($urandom_range(99) < rpct);
            @(negedge clock);
            acc = pixel_valid_i && pixel_ready_o;
            @(posedge clock);
            #1;
            if (acc) idx++;
            guard++;
            if (guard > 2000) begin
                n_checks++;
                n_err++;
                $display("FAIL send_timeout: got=%0d expected=%0d accepted", idx - first, count);
                break;
            end
        end
        pixel_valid_i = 1'b0;
    endtask

    task automatic drain();
        pixel_valid_i  = 1'b0;
        window_ready_i = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("queue_empty", 72'(expq.size()), 72'd0);
    endtask

    task automatic clear_stats();
        mlog.delete();
        got_win  = 0;
        got_last = 0;
    endtask

    task automatic check_frame(input string tag, input int base, input int first);
        for (int k = 0; k < 6; k++) begin
            if (mlog.size() <= first + k) begin
                n_checks++;
                n_err++;
                $display("FAIL %s_missing: got=%0d expected>%0d windows", tag, mlog.size(), first + k);
            end else begin
                chk($sformatf("%s_win%0d", tag, k), mlog[first+k].px, exp_at(base + tl6[k]));
                chk($sformatf("%s_last%0d", tag, k), {71'b0, mlog[first+k].last}, {71'b0, (k == 5)});
            end
        end
    endtask

    task automatic check_counts(input string tag, input int nwin, input int nlast);
        chk({tag, "_windows"}, 72'(got_win), 72'(nwin));
        chk({tag, "_lasts"}, 72'(got_last), 72'(nlast));
    endtask

    initial begin
        reset          = 1'b1;
        pixel_valid_i  = 1'b0;
        pixel_i        = '0;
        window_ready_i = 1'b1;
        #1;
        chk("reset_valid", {71'b0, window_valid_o}, 72'd0);
        chk("reset_last", {71'b0, frame_last_o}, 72'd0);
        chk("reset_window", dut_win(), 72'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Continuous stream with the sink always ready.
        clear_stats();
        send(0, 20, 100, 100);
        drain();
        check_frame("cont", 0, 0);
        check_counts("cont", 6, 1);

        // Back-pressure on the very first window.
        clear_stats();
        send(0, 13, 100, 0);
        pixel_valid_i  = 1'b1;
        pixel_i        = 8'd13;
        window_ready_i = 1'b0;
        repeat (10) begin
            @(negedge clock);
            chk("bp_ready_low", {71'b0, pixel_ready_o}, 72'd0);
            chk("bp_valid_high", {71'b0, window_valid_o}, 72'd1);
            chk("bp_window_hold", dut_win(), exp_at(0));
            @(posedge clock);
            #1;
        end
        send(13, 7, 100, 100);
        drain();
        check_frame("bp", 0, 0);
        check_counts("bp", 6, 1);

        // Gapped input.
        clear_stats();
        send(0, 20, 50, 100);
        drain();
        check_frame("gap", 0, 0);
        check_counts("gap", 6, 1);

        // Gapped input with random sink stalls.
        clear_stats();
        send(0, 20, 70, 60);
        drain();
        check_frame("rand", 0, 0);
        check_counts("rand", 6, 1);

        // Two frames back to back, second offset by 100.
        clear_stats();
        send(0, 40, 100, 100);
        drain();
        check_frame("b2b0", 0, 0);
        check_frame("b2b1", 100, 6);
        check_counts("b2b", 12, 2);

        // Asynchronous reset in the middle of a frame.
        clear_stats();
        send(0, 9, 100, 100);
        reset = 1'b1;
        #1;
        chk("midrst_valid", {71'b0, window_valid_o}, 72'd0);
        chk("midrst_last", {71'b0, frame_last_o}, 72'd0);
        chk("midrst_window", dut_win(), 72'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        clear_stats();
        send(0, 20, 100, 100);
        drain();
        check_frame("rst", 0, 0);
        check_counts("rst", 6, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
